nn_regfile: RTL and testbench
=============================

Name: nn_regfile

Overview:
- Parametrised register file for the NN datapath core.
- Provides NUM_RD combinational read ports, one core write port with a position tag, an operand/pos side port, and a flattened weight-matrix export from the top WEIGHT_ROWS registers.
- Adds a burst loader that streams DATA_W words into consecutive registers over a valid/ready handshake. Weights and bias can be refilled without core write instructions.
- Sits between the decode/execute stages and the FC/Conv/MaxPool compute array.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 16, number of registers (power of two, >= WEIGHT_ROWS); AW = clog2(DEPTH).
- POS_W, 4, width of the per-register position tag.
- NUM_RD, 2, number of combinational read ports.
- WEIGHT_ROWS, 4, number of top registers exported as the weight matrix.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- rd_addr_i  in  NUM_RD*AW  read addresses; port p uses slice [p*AW +: AW].
- rd_data_o  out  NUM_RD*DATA_W  read data; port p uses slice [p*DATA_W +: DATA_W].
- op_addr_i  in  AW  operand-port address.
- op_data_o  out  DATA_W  register[op_addr_i].
- op_pos_o  out  POS_W  pos[op_addr_i].
- wr_en_i  in  1  core write enable.
- wr_addr_i  in  AW  core write address.
- wr_data_i  in  DATA_W  core write data.
- wr_pos_i  in  POS_W  position tag written with the data.
- weight_matrix_o  out  WEIGHT_ROWS*DATA_W  slice i = register[DEPTH-1-i].
- ld_start_i  in  1  start-burst request (sampled in IDLE only).
- ld_base_i  in  AW  first destination register.
- ld_count_i  in  AW+1  number of words in the burst.
- ld_valid_i  in  1  loader data valid.
- ld_data_i  in  DATA_W  loader data word.
- ld_ready_o  out  1  loader can accept a beat this cycle.
- ld_busy_o  out  1  burst in progress.
- ld_done_o  out  1  one-cycle pulse when a burst finishes.

Behaviour:
- Reset (async, active-high):
  - All registers and pos tags are 0.
  - FSM goes to IDLE; ld_busy_o, ld_ready_o and ld_done_o are 0.
  - Read outputs are therefore 0.
  - Reset mid-burst aborts the burst with no done pulse.
- Reads:
  - Purely combinational from the registers; zero-cycle latency.
  - A write becomes visible the cycle after its clock edge (see BYPASS_EN).
- Core write: if wr_en_i, register[wr_addr_i] <= wr_data_i and pos[wr_addr_i] <= wr_pos_i at the rising edge.
- Loader FSM, states IDLE, LOAD, DONE:
  - IDLE: on ld_start_i with clamped count N = min(ld_count_i, DEPTH):
    - N > 0: latch base and N, clear the beat index, go to LOAD.
    - N == 0: go to DONE directly with no writes.
  - LOAD: ld_busy_o = 1 and ld_ready_o = !wr_en_i; the core write always wins arbitration.
    - A beat is accepted when ld_valid_i & ld_ready_o.
    - On accept: register[(base+idx) mod DEPTH] <= ld_data_i and its pos <= 0; idx increments.
    - The last beat (idx == N-1) moves the FSM to DONE.
  - DONE: ld_done_o = 1 for exactly one cycle, then IDLE. ld_busy_o stays 1 in DONE.
  - ld_start_i outside IDLE is ignored.
- Wrap-around: destination address is (base+idx) mod DEPTH. For example, base 14 with count 4 writes 14, 15, 0, 1.
- Accepted beats may be non-consecutive; idle cycles (valid low or ready low) do not advance idx.
- Simultaneous core write and loader valid: the core write happens and the loader beat stalls, since ready is low. No address collision is possible.
- weight_matrix_o is combinational and tracks core writes and loader writes alike.

Optional Feature:
- Macro: NN_REGFILE_BYPASS_EN.
- Defined: a read port or op port whose address matches a write occurring in the same cycle returns the write data and tag combinationally. The write source is either the core write or an accepted loader beat (tag 0 for a loader beat). weight_matrix_o is bypassed the same way.
- Undefined: all reads return the pre-edge register contents.

Decomposition:
- Package nn_regfile_pkg:
  - loader state enum (IDLE, LOAD, DONE);
  - function computing AW from DEPTH;
  - default DATA_W/POS_W constants.
- Sub-module nn_regfile_loader:
  - contains the FSM, the base/count/idx registers and the handshake outputs;
  - outputs ld_we, ld_waddr, ld_wdata to the register array in nn_regfile.

Test Plan:
- Reset then read all addresses on every port -> all rd_data_o, op_data_o and weight_matrix_o are 0; ld_busy_o = 0.
- Core write addr 4 = 0x0753320C with pos 0x3, then op_addr 4 -> next cycle op_data_o = 0x0753320C and op_pos_o = 0x3.
- Burst base 12, count 4, data 0x17430 30F, 0x08785B1F, 0x01010101, 0x01010101 streamed on consecutive cycles:
  - the words are stated here byte by byte as 0x1743030F, 0x08785B1F, 0x01010101, 0x01010101;
  - expect weight_matrix_o[31:0] = reg15 = 0x01010101 and weight_matrix_o[127:96] = reg12 = 0x1743030F;
  - expect ld_done_o to pulse once, one cycle after the 4th beat.
- Burst base 14, count 4 with wr_en_i asserted on beat 2 -> ld_ready_o is low that cycle and the beat is held; registers 14, 15, 0, 1 are written and the core write also lands.
- ld_count_i = 0 -> no register changes; ld_done_o pulses 1 cycle after start. ld_count_i = 20 -> clamped to 16 beats.
- Reset asserted after beat 2 of a 4-beat burst -> all registers 0, FSM IDLE, no ld_done_o pulse. With NN_REGFILE_BYPASS_EN, a same-cycle write and read to addr 3 returns the new data.

Source files
------------

// File: rtl/nn_regfile_pkg.sv
// Shared types and constants for the NN datapath register file.
// Optional same-cycle write-to-read bypass is enabled with NN_REGFILE_BYPASS_EN.
package nn_regfile_pkg;

  localparam int NN_DATA_W = 32;
  localparam int NN_POS_W  = 4;
  localparam int NN_DEPTH  = 16;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

  // Address width for a register array of the given depth (at least 1 bit).
  function automatic int calc_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/nn_regfile_if.sv
// Bus bundle between the decode/execute stages and the NN register file.
// Optional same-cycle bypass (NN_REGFILE_BYPASS_EN) does not change this bundle.
interface nn_regfile_if import nn_regfile_pkg::*; #(
  parameter int DATA_W      = NN_DATA_W,
  parameter int DEPTH       = NN_DEPTH,
  parameter int POS_W       = NN_POS_W,
  parameter int NUM_RD      = 2,
  parameter int WEIGHT_ROWS = 4
);
  localparam int AW = calc_aw(DEPTH);

  logic [NUM_RD*AW-1:0]          rd_addr_i;
  logic [NUM_RD*DATA_W-1:0]      rd_data_o;
  logic [AW-1:0]                 op_addr_i;
  logic [DATA_W-1:0]             op_data_o;
  logic [POS_W-1:0]              op_pos_o;
  logic                          wr_en_i;
  logic [AW-1:0]                 wr_addr_i;
  logic [DATA_W-1:0]             wr_data_i;
  logic [POS_W-1:0]              wr_pos_i;
  logic [WEIGHT_ROWS*DATA_W-1:0] weight_matrix_o;
  logic                          ld_start_i;
  logic [AW-1:0]                 ld_base_i;
  logic [AW:0]                   ld_count_i;
  logic                          ld_valid_i;
  logic [DATA_W-1:0]             ld_data_i;
  logic                          ld_ready_o;
  logic                          ld_busy_o;
  logic                          ld_done_o;

  modport master (
    output rd_addr_i, op_addr_i, wr_en_i, wr_addr_i, wr_data_i, wr_pos_i,
           ld_start_i, ld_base_i, ld_count_i, ld_valid_i, ld_data_i,
    input  rd_data_o, op_data_o, op_pos_o, weight_matrix_o,
           ld_ready_o, ld_busy_o, ld_done_o
  );

  modport slave (
    input  rd_addr_i, op_addr_i, wr_en_i, wr_addr_i, wr_data_i, wr_pos_i,
           ld_start_i, ld_base_i, ld_count_i, ld_valid_i, ld_data_i,
    output rd_data_o, op_data_o, op_pos_o, weight_matrix_o,
           ld_ready_o, ld_busy_o, ld_done_o
  );

endinterface

// File: rtl/nn_regfile_loader.sv
// Burst loader: streams words into consecutive registers over valid/ready,
// yielding to the core write port whenever both want the array.
module nn_regfile_loader import nn_regfile_pkg::*; #(
  parameter int DATA_W = NN_DATA_W,
  parameter int DEPTH  = NN_DEPTH,
  localparam int AW    = calc_aw(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              ld_start_i,
  input  logic [AW-1:0]     ld_base_i,
  input  logic [AW:0]       ld_count_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              wr_en_i,
  output logic              ld_ready_o,
  output logic              ld_busy_o,
  output logic              ld_done_o,
  output logic              ld_we_o,
  output logic [AW-1:0]     ld_waddr_o,
  output logic [DATA_W-1:0] ld_wdata_o
);

  ld_state_e     r_state, w_state_nxt;
  logic [AW-1:0] r_base;
  logic [AW:0]   r_cnt, r_idx, w_cnt_clamp;

  assign w_cnt_clamp = (ld_count_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : ld_count_i;
  // Truncation to AW bits gives the mod-DEPTH wrap for free.
  assign ld_waddr_o  = r_base + r_idx[AW-1:0];
  assign ld_wdata_o  = ld_data_i;

  always_comb begin
    w_state_nxt = r_state;
    ld_ready_o  = 1'b0;
    ld_busy_o   = 1'b0;
    ld_done_o   = 1'b0;
    ld_we_o     = 1'b0;
    case (r_state)
      LD_IDLE: begin
        if (ld_start_i) w_state_nxt = (w_cnt_clamp != '0) ? LD_LOAD : LD_DONE;
      end
      LD_LOAD: begin
        ld_busy_o  = 1'b1;
        ld_ready_o = !wr_en_i;
        ld_we_o    = ld_valid_i && !wr_en_i;
        if (ld_we_o && (r_idx == r_cnt - 1'b1)) w_state_nxt = LD_DONE;
      end
      LD_DONE: begin
        ld_busy_o   = 1'b1;
        ld_done_o   = 1'b1;
        w_state_nxt = LD_IDLE;
      end
      default: w_state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_state <= LD_IDLE;
      r_base  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == LD_IDLE && ld_start_i) begin
        r_base <= ld_base_i;
        r_cnt  <= w_cnt_clamp;
        r_idx  <= '0;
      end else if (ld_we_o) begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nn_regfile.sv
// Parametrised NN register file: combinational read/op ports, tagged core write,
// burst loader and weight-matrix export. Define NN_REGFILE_BYPASS_EN for write bypass.
module nn_regfile import nn_regfile_pkg::*; #(
  parameter int DATA_W      = NN_DATA_W,
  parameter int DEPTH       = NN_DEPTH,
  parameter int POS_W       = NN_POS_W,
  parameter int NUM_RD      = 2,
  parameter int WEIGHT_ROWS = 4,
  localparam int AW         = calc_aw(DEPTH)
) (
  input  logic         clk_i,
  input  logic         reset,
  nn_regfile_if.slave  bus
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [POS_W-1:0]  r_pos [DEPTH];

  logic              w_ld_we;
  logic [AW-1:0]     w_ld_waddr;
  logic [DATA_W-1:0] w_ld_wdata;

  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [POS_W-1:0]  w_wpos;

  logic [NUM_RD-1:0][DATA_W-1:0]      w_rd;
  logic [WEIGHT_ROWS-1:0][DATA_W-1:0] w_wm;

  nn_regfile_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_loader (
    .clk_i      (clk_i),
    .reset      (reset),
    .ld_start_i (bus.ld_start_i),
    .ld_base_i  (bus.ld_base_i),
    .ld_count_i (bus.ld_count_i),
    .ld_valid_i (bus.ld_valid_i),
    .ld_data_i  (bus.ld_data_i),
    .wr_en_i    (bus.wr_en_i),
    .ld_ready_o (bus.ld_ready_o),
    .ld_busy_o  (bus.ld_busy_o),
    .ld_done_o  (bus.ld_done_o),
    .ld_we_o    (w_ld_we),
    .ld_waddr_o (w_ld_waddr),
    .ld_wdata_o (w_ld_wdata)
  );

  // The loader only writes when the core port is idle, so a simple mux suffices.
  assign w_we    = bus.wr_en_i | w_ld_we;
  assign w_waddr = bus.wr_en_i ? bus.wr_addr_i : w_ld_waddr;
  assign w_wdata = bus.wr_en_i ? bus.wr_data_i : w_ld_wdata;
  assign w_wpos  = bus.wr_en_i ? bus.wr_pos_i  : '0;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
        r_pos[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
      r_pos[w_waddr] <= w_wpos;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd[p] = r_mem[bus.rd_addr_i[p*AW +: AW]];
`ifdef NN_REGFILE_BYPASS_EN
      if (w_we && (w_waddr == bus.rd_addr_i[p*AW +: AW])) w_rd[p] = w_wdata;
`endif
    end
    for (int i = 0; i < WEIGHT_ROWS; i++) begin
      w_wm[i] = r_mem[AW'(DEPTH-1-i)];
`ifdef NN_REGFILE_BYPASS_EN
      if (w_we && (w_waddr == AW'(DEPTH-1-i))) w_wm[i] = w_wdata;
`endif
    end
  end

  always_comb begin
    bus.op_data_o = r_mem[bus.op_addr_i];
    bus.op_pos_o  = r_pos[bus.op_addr_i];
`ifdef NN_REGFILE_BYPASS_EN
    if (w_we && (w_waddr == bus.op_addr_i)) begin
      bus.op_data_o = w_wdata;
      bus.op_pos_o  = w_wpos;
    end
`endif
  end

  assign bus.rd_data_o       = w_rd;
  assign bus.weight_matrix_o = w_wm;

endmodule

// File: tb/tb_nn_regfile.sv
// Scoreboard bench for nn_regfile: stimulus queues expectations, a negedge
// monitor pops and compares them against the live outputs.
module tb_nn_regfile;

  logic clk_i = 1'b0;
  logic reset = 1'b1;
  always #5 clk_i = ~clk_i;

  nn_regfile_if #(.DATA_W(32), .DEPTH(16), .POS_W(4), .NUM_RD(2), .WEIGHT_ROWS(4)) bus ();

  nn_regfile #(.DATA_W(32), .DEPTH(16), .POS_W(4), .NUM_RD(2), .WEIGHT_ROWS(4)) dut (
    .clk_i (clk_i),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  localparam int S_RD0 = 0, S_RD1 = 1, S_OPD = 2, S_OPP = 3, S_BUSY = 4,
                 S_RDY = 5, S_DONE = 6, S_DCNT = 7, S_WM = 10;

  chk_t        q[$];
  logic        chk_vld = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          dcnt    = 0;
  logic [31:0] m  [16];
  logic [3:0]  mp [16];

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_RD0:  return bus.rd_data_o[31:0];
      S_RD1:  return bus.rd_data_o[63:32];
      S_OPD:  return bus.op_data_o;
      S_OPP:  return {28'd0, bus.op_pos_o};
      S_BUSY: return {31'd0, bus.ld_busy_o};
      S_RDY:  return {31'd0, bus.ld_ready_o};
      S_DONE: return {31'd0, bus.ld_done_o};
      S_DCNT: return dcnt;
      default: return bus.weight_matrix_o[(sel-S_WM)*32 +: 32];
    endcase
  endfunction

  always @(negedge clk_i) begin
    if (bus.ld_done_o) dcnt++;
    if (chk_vld) begin
      while (q.size() > 0) begin
        chk_t c;
        logic [31:0] act;
        c   = q.pop_front();
        act = sample(c.sel);
        n_tests++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (t=%0t)", c.nm, act, c.exp, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic exp_chk(input string nm, input int sel, input logic [31:0] e);
    chk_t c;
    c.nm = nm; c.sel = sel; c.exp = e;
    q.push_back(c);
    chk_vld = 1'b1;
  endtask

  task automatic beat(input logic [31:0] d);
    bus.ld_valid_i = 1'b1;
    bus.ld_data_i  = d;
    exp_chk("beat_busy", S_BUSY, 1);
    exp_chk("beat_ready", S_RDY, 1);
    tick();
  endtask

  task automatic dump(input string tag);
    for (int a = 0; a < 16; a++) begin
      bus.rd_addr_i = {4'(15 - a), 4'(a)};
      bus.op_addr_i = 4'(a);
      exp_chk({tag, "_rd0"}, S_RD0, m[a]);
      exp_chk({tag, "_rd1"}, S_RD1, m[15 - a]);
      exp_chk({tag, "_opd"}, S_OPD, m[a]);
      exp_chk({tag, "_opp"}, S_OPP, {28'd0, mp[a]});
      tick();
    end
    for (int i = 0; i < 4; i++) exp_chk({tag, "_wm"}, S_WM + i, m[15 - i]);
    exp_chk({tag, "_busy"}, S_BUSY, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_addr_i = '0;  bus.op_addr_i = '0;
    bus.wr_en_i = 0;     bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.wr_pos_i = '0;
    bus.ld_start_i = 0;  bus.ld_base_i = '0; bus.ld_count_i = '0;
    bus.ld_valid_i = 0;  bus.ld_data_i = '0;
    for (int i = 0; i < 16; i++) begin m[i] = '0; mp[i] = '0; end

    // Reset state
    tick();
    bus.rd_addr_i = 8'h F0;
    exp_chk("rst_rd0", S_RD0, 0);  exp_chk("rst_rd1", S_RD1, 0);
    exp_chk("rst_opd", S_OPD, 0);  exp_chk("rst_busy", S_BUSY, 0);
    exp_chk("rst_rdy", S_RDY, 0);  exp_chk("rst_done", S_DONE, 0);
    for (int i = 0; i < 4; i++) exp_chk("rst_wm", S_WM + i, 0);
    tick();
    reset = 1'b0;
    dump("post_rst");

    // Core write addr 4, visible next cycle
    bus.wr_en_i = 1; bus.wr_addr_i = 4; bus.wr_data_i = 32'h0753320C; bus.wr_pos_i = 4'h3;
    bus.op_addr_i = 4;
`ifdef NN_REGFILE_BYPASS_EN
    exp_chk("wr_same_cycle", S_OPD, 32'h0753320C);
`else
    exp_chk("wr_same_cycle", S_OPD, 32'h0);
`endif
    tick();
    bus.wr_en_i = 0;
    exp_chk("wr_opd", S_OPD, 32'h0753320C);
    exp_chk("wr_opp", S_OPP, 32'h3);
    tick();
    m[4] = 32'h0753320C; mp[4] = 4'h3;

    // Burst base 12, count 4, consecutive beats
    bus.ld_start_i = 1; bus.ld_base_i = 12; bus.ld_count_i = 4;
    exp_chk("b1_idle_busy", S_BUSY, 0);
    tick();
    bus.ld_start_i = 0;
    beat(32'h1743030F); beat(32'h08785B1F); beat(32'h01010101); beat(32'h01010101);
    bus.ld_valid_i = 0;
    exp_chk("b1_done", S_DONE, 1);
    exp_chk("b1_done_busy", S_BUSY, 1);
    tick();
    exp_chk("b1_done_off", S_DONE, 0);
    exp_chk("b1_idle", S_BUSY, 0);
    exp_chk("b1_wm0", S_WM + 0, 32'h01010101);
    exp_chk("b1_wm1", S_WM + 1, 32'h01010101);
    exp_chk("b1_wm2", S_WM + 2, 32'h08785B1F);
    exp_chk("b1_wm3", S_WM + 3, 32'h1743030F);
    tick();
    m[12] = 32'h1743030F; m[13] = 32'h08785B1F; m[14] = 32'h01010101; m[15] = 32'h01010101;

    // Burst base 14 wraps; core write stalls beat 2; an idle cycle mid-burst
    bus.ld_start_i = 1; bus.ld_base_i = 14; bus.ld_count_i = 4;
    tick();
    bus.ld_start_i = 0;
    beat(32'h11112222);
    bus.ld_valid_i = 1; bus.ld_data_i = 32'h33334444;
    bus.wr_en_i = 1; bus.wr_addr_i = 5; bus.wr_data_i = 32'hCAFEF00D; bus.wr_pos_i = 4'h7;
    exp_chk("b2_stall_rdy", S_RDY, 0);
    tick();
    bus.wr_en_i = 0;
    beat(32'h33334444);
    bus.ld_valid_i = 0;
    exp_chk("b2_gap_busy", S_BUSY, 1);
    exp_chk("b2_gap_done", S_DONE, 0);
    tick();
    beat(32'h55556666); beat(32'h77778888);
    bus.ld_valid_i = 0;
    exp_chk("b2_done", S_DONE, 1);
    tick();
    m[14] = 32'h11112222; m[15] = 32'h33334444; m[0] = 32'h55556666; m[1] = 32'h77778888;
    m[5] = 32'hCAFEF00D; mp[5] = 4'h7;
    dump("b2");

    // Zero-count burst: straight to DONE, no writes
    bus.ld_start_i = 1; bus.ld_base_i = 7; bus.ld_count_i = 0;
    tick();
    bus.ld_start_i = 0;
    exp_chk("c0_done", S_DONE, 1);
    exp_chk("c0_busy", S_BUSY, 1);
    exp_chk("c0_rdy", S_RDY, 0);
    tick();
    exp_chk("c0_done_off", S_DONE, 0);
    tick();
    dump("c0");

    // Count 20 clamps to 16 beats; start mid-burst is ignored
    bus.ld_start_i = 1; bus.ld_base_i = 3; bus.ld_count_i = 20;
    tick();
    bus.ld_start_i = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin bus.ld_start_i = 1; bus.ld_base_i = 0; bus.ld_count_i = 0; end
      if (k == 15) exp_chk("c20_not_done", S_DONE, 0);
      beat(32'h10000000 + 32'(k));
      bus.ld_start_i = 0;
      m[(3 + k) % 16] = 32'h10000000 + 32'(k); mp[(3 + k) % 16] = 4'h0;
    end
    bus.ld_valid_i = 0;
    exp_chk("c20_done", S_DONE, 1);
    tick();
    exp_chk("done_count", S_DCNT, 4);
    tick();
    dump("c20");

    // Reset mid-burst after two beats
    bus.ld_start_i = 1; bus.ld_base_i = 8; bus.ld_count_i = 4;
    tick();
    bus.ld_start_i = 0;
    beat(32'h99999999); beat(32'h99999999);
    bus.ld_valid_i = 1; bus.ld_data_i = 32'hAAAAAAAA;
    reset = 1'b1;
    #1;
    bus.rd_addr_i = {4'd9, 4'd8};
    exp_chk("mrst_busy", S_BUSY, 0);
    exp_chk("mrst_rdy", S_RDY, 0);
    exp_chk("mrst_rd0", S_RD0, 0);
    exp_chk("mrst_rd1", S_RD1, 0);
    tick();
    reset = 1'b0;
    bus.ld_valid_i = 0;
    exp_chk("mrst_no_done", S_DONE, 0);
    tick();
    exp_chk("mrst_dcnt", S_DCNT, 4);
    for (int i = 0; i < 16; i++) begin m[i] = '0; mp[i] = '0; end
    tick();
    dump("mrst");

    // Same-cycle write and read (addr 3 on rd0, addr 15 on weight row 0)
    bus.rd_addr_i = {4'd0, 4'd3}; bus.op_addr_i = 3;
    bus.wr_en_i = 1; bus.wr_addr_i = 3; bus.wr_data_i = 32'hDEADBEEF; bus.wr_pos_i = 4'h5;
`ifdef NN_REGFILE_BYPASS_EN
    exp_chk("byp_rd0", S_RD0, 32'hDEADBEEF);
    exp_chk("byp_opp", S_OPP, 32'h5);
`else
    exp_chk("byp_rd0", S_RD0, 32'h0);
    exp_chk("byp_opp", S_OPP, 32'h0);
`endif
    tick();
    bus.wr_addr_i = 15; bus.wr_data_i = 32'h0BADF00D;
    exp_chk("post_rd0", S_RD0, 32'hDEADBEEF);
    exp_chk("post_opp", S_OPP, 32'h5);
`ifdef NN_REGFILE_BYPASS_EN
    exp_chk("byp_wm0", S_WM + 0, 32'h0BADF00D);
`else
    exp_chk("byp_wm0", S_WM + 0, 32'h0);
`endif
    tick();
    bus.wr_en_i = 0;
    exp_chk("post_wm0", S_WM + 0, 32'h0BADF00D);
    tick();
    tick();

    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
